ddr3_cache_arbiter: RTL and testbench

- Shares the single DDR3 cache request port (32-bit address, 256-bit line data, rd/we/ack) among NUM_PORTS requesters, e.g. I-fetch, D-access, VGA line fetch.
- Round-robin grant, one transaction in flight, grant held until the cache acks.
- Sits between requester masters and the DDR3 cache.
- Registers the cache-side request so cache timing is independent of requester decode.

---
 rtl/ddr3_cache_arbiter_pkg.sv | 9 +
 rtl/ddr3_arb_rr_pick.sv | 28 ++
 rtl/ddr3_cache_arbiter.sv | 75 +++++++
 tb/tb_ddr3_cache_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ddr3_cache_arbiter_pkg.sv
// ddr3_cache_arbiter_pkg: shared FSM states, bus widths and the grant-index width helper
package ddr3_cache_arbiter_pkg;
  localparam int LINE_BITS = 256;
  localparam int ADDR_W = 32;
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  function automatic int get_width(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction
endpackage

// File: rtl/ddr3_arb_rr_pick.sv
// ddr3_arb_rr_pick: combinational winner select; round-robin after i_last, or lowest index under DDR3_ARB_FIXED_PRIO_EN
module ddr3_arb_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_BITS = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PORT_BITS-1:0] i_last,
  output logic [PORT_BITS-1:0] o_win,
  output logic                 o_valid
);
  assign o_valid = |i_req;
`ifdef DDR3_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last;
  // scan downward so the lowest requesting index is the final assignment
  always_comb begin
    o_win = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) o_win = i_req[j] ? PORT_BITS'(j) : o_win;
  end
`else
  // scan distances from far to near so the nearest port after i_last wins
  always_comb begin
    o_win = '0;
    for (int j = NUM_PORTS; j >= 1; j--)
      o_win = i_req[(int'(i_last) + j) % NUM_PORTS] ? PORT_BITS'((int'(i_last) + j) % NUM_PORTS) : o_win;
  end
`endif
endmodule

// File: rtl/ddr3_cache_arbiter.sv
// ddr3_cache_arbiter: shares one DDR3 cache port among NUM_PORTS requesters; DDR3_ARB_FIXED_PRIO_EN selects fixed priority
module ddr3_cache_arbiter
  import ddr3_cache_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 3,
  localparam int PORT_BITS = get_width(NUM_PORTS - 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_PORTS*LINE_BITS-1:0] req_data_i,
  input  logic [NUM_PORTS-1:0]           req_rd_i,
  input  logic [NUM_PORTS-1:0]           req_we_i,
  output logic [LINE_BITS-1:0]           req_data_o,
  output logic [NUM_PORTS-1:0]           req_ack_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic [LINE_BITS-1:0]           mem_data_o,
  output logic                           mem_rd_o,
  output logic                           mem_we_o,
  input  logic [LINE_BITS-1:0]           mem_data_i,
  input  logic                           mem_ack_i,
  output logic [PORT_BITS-1:0]           grant_o,
  output logic                           busy_o
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_BITS-1:0] r_data;
  logic r_rd, r_we;
  logic [PORT_BITS-1:0] r_grant, w_win;
  logic [NUM_PORTS-1:0] w_req;
  logic w_valid, w_take, w_done;
  assign w_req = req_rd_i | req_we_i;
  assign w_take = (r_state == S_IDLE) && w_valid;
  assign w_done = (r_state == S_BUSY) && mem_ack_i;
  ddr3_arb_rr_pick #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) u_pick (
    .i_req  (w_req),
    .i_last (r_grant),
    .o_win  (w_win),
    .o_valid(w_valid)
  );
  // state register
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  // next state: idle launches on any request, busy waits for the cache ack
  always_comb begin
    w_next = r_state;
    w_next = w_take ? S_BUSY : w_done ? S_IDLE : w_next;
  end
  // cache-side request registers: latched on grant, strobes cleared on ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_rd    <= 1'b0;
      r_we    <= 1'b0;
      r_grant <= PORT_BITS'(NUM_PORTS - 1);
    end else if (w_take) begin
      r_grant <= w_win;
      r_addr  <= req_addr_i[ADDR_W*int'(w_win) +: ADDR_W];
      r_data  <= req_data_i[LINE_BITS*int'(w_win) +: LINE_BITS];
      r_we    <= req_we_i[w_win];
      r_rd    <= ~req_we_i[w_win];
    end else if (w_done) begin
      r_rd <= 1'b0;
      r_we <= 1'b0;
    end
  end
  assign req_ack_o  = w_done ? (NUM_PORTS'(1) << r_grant) : '0;
  assign req_data_o = mem_data_i;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_data;
  assign mem_rd_o   = r_rd;
  assign mem_we_o   = r_we;
  assign grant_o    = r_grant;
  assign busy_o     = r_state == S_BUSY;
endmodule

// File: tb/tb_ddr3_cache_arbiter.sv
// tb_ddr3_cache_arbiter: directed checks of grant order, strobes, ack routing and reset abort
module tb_ddr3_cache_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [95:0] req_addr_i = '0;
  logic [767:0] req_data_i = '0;
  logic [2:0] req_rd_i = '0, req_we_i = '0;
  logic [255:0] req_data_o, mem_data_o, mem_data_i = '0;
  logic [2:0] req_ack_o;
  logic [31:0] mem_addr_o;
  logic mem_rd_o, mem_we_o, mem_ack_i = 1'b0, busy_o;
  logic [1:0] grant_o;
  int n_vec = 0, n_bad = 0;
  logic [1:0] exp_g [3];

  ddr3_cache_arbiter #(.NUM_PORTS(3)) dut (
    .clk(clk), .rst(rst), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_rd_i(req_rd_i), .req_we_i(req_we_i), .req_data_o(req_data_o), .req_ack_o(req_ack_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_rd_o(mem_rd_o), .mem_we_o(mem_we_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rd", mem_rd_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 2);
    chk("rst_ack", req_ack_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    rst = 1'b0;
    // port1 read, cache acks after 5 cycles
    req_addr_i[32 +: 32] = 32'h40;
    req_rd_i = 3'b010;
    @(negedge clk);
    chk("p1_rd", mem_rd_o, 1);
    chk("p1_addr", mem_addr_o, 32'h40);
    chk("p1_we", mem_we_o, 0);
    chk("p1_grant", grant_o, 1);
    chk("p1_busy", busy_o, 1);
    repeat (4) @(negedge clk);
    chk("p1_hold_rd", mem_rd_o, 1);
    chk("p1_noack", req_ack_o, 0);
    mem_ack_i = 1'b1;
    mem_data_i = {32{8'hA5}};
    #1;
    chk("p1_ack", req_ack_o, 3'b010);
    chk("p1_data", req_data_o, {32{8'hA5}});
    @(negedge clk);
    mem_ack_i = 1'b0;
    req_rd_i = 3'b000;
    chk("p1_rd_after", mem_rd_o, 0);
    chk("p1_ack_after", req_ack_o, 0);
    chk("p1_idle", busy_o, 0);
    // round-robin fairness from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_rd_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_grant", grant_o, i % 3);
      chk("rr_busy", busy_o, 1);
      @(negedge clk);
      if (i > 0) req_rd_i[(i - 1) % 3] = 1'b1;
      mem_ack_i = 1'b1;
      #1;
      chk("rr_ack", req_ack_o, 3'b001 << (i % 3));
      @(negedge clk);
      mem_ack_i = 1'b0;
      req_rd_i[i % 3] = 1'b0;
      chk("rr_idle", busy_o, 0);
    end
    req_rd_i = 3'b000;
    // port2 rd+we together: write wins; inputs ignored while busy
    @(negedge clk);
    req_addr_i[64 +: 32] = 32'h80;
    req_data_i[512 +: 256] = 256'h1234;
    req_rd_i = 3'b100;
    req_we_i = 3'b100;
    @(negedge clk);
    chk("wr_we", mem_we_o, 1);
    chk("wr_rd", mem_rd_o, 0);
    chk("wr_data", mem_data_o, 256'h1234);
    chk("wr_grant", grant_o, 2);
    req_addr_i[64 +: 32] = 32'hFFFF0000;
    req_data_i[512 +: 256] = 256'hBEEF;
    @(negedge clk);
    chk("wr_hold_addr", mem_addr_o, 32'h80);
    chk("wr_hold_data", mem_data_o, 256'h1234);
    mem_ack_i = 1'b1;
    #1;
    chk("wr_ack", req_ack_o, 3'b100);
    @(negedge clk);
    mem_ack_i = 1'b0;
    req_rd_i = 3'b000;
    req_we_i = 3'b000;
    chk("wr_we_after", mem_we_o, 0);
    // port0 address changed while busy
    req_addr_i[0 +: 32] = 32'h100;
    req_rd_i = 3'b001;
    @(negedge clk);
    chk("p0_addr", mem_addr_o, 32'h100);
    req_addr_i[0 +: 32] = 32'h200;
    @(negedge clk);
    chk("p0_hold_addr", mem_addr_o, 32'h100);
    mem_ack_i = 1'b1;
    #1;
    chk("p0_ack", req_ack_o, 3'b001);
    @(negedge clk);
    mem_ack_i = 1'b0;
    req_rd_i = 3'b000;
    // spurious ack while idle
    @(negedge clk);
    mem_ack_i = 1'b1;
    #1;
    chk("sp_ack", req_ack_o, 0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk("sp_busy", busy_o, 0);
    chk("sp_rd", mem_rd_o, 0);
    chk("sp_grant", grant_o, 0);
    // ports 0 and 2 request continuously
`ifdef DDR3_ARB_FIXED_PRIO_EN
    exp_g = '{2'd0, 2'd0, 2'd0};
`else
    exp_g = '{2'd2, 2'd0, 2'd2};
`endif
    req_rd_i = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pr_grant", grant_o, exp_g[i]);
      mem_ack_i = 1'b1;
      #1;
      chk("pr_ack", req_ack_o, 3'b001 << exp_g[i]);
      @(negedge clk);
      mem_ack_i = 1'b0;
      chk("pr_idle", busy_o, 0);
    end
    req_rd_i = 3'b000;
    // reset during busy abandons the transaction
    @(negedge clk);
    req_rd_i = 3'b010;
    @(negedge clk);
    chk("ab_busy_pre", busy_o, 1);
    rst = 1'b1;
    req_rd_i = 3'b000;
    @(negedge clk);
    chk("ab_rd", mem_rd_o, 0);
    chk("ab_busy", busy_o, 0);
    chk("ab_grant", grant_o, 2);
    chk("ab_ack", req_ack_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ab_idle", busy_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
